// File: rtl/ninjakun_clkmon.sv
// ninjakun_clkmon: checker for one divided clock of the video/CPU clock tree.
// Synchronizes CLKIN into the MCLK domain, recovers single-cycle rise/fall
// enables, measures the rise-to-rise period, tracks lock and counts violations.
// Optional build macro NINJAKUN_CLKMON_DUTY_EN adds a HIGH_TIME output and
// makes an off-nominal high time count as a bad period.
//
// state | meaning
// IDLE  | no measurement running; the next rise starts one
// ACQ   | measuring, counting consecutive good periods toward lock
// LOCK  | locked; a bad period or a stall is recorded as a violation
module ninjakun_clkmon #(
  parameter int EXP_PERIOD  = 8,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic       CLKIN,
  input  logic       CLR_ERR,
  output logic       CEN_RISE,
  output logic       CEN_FALL,
  output logic [7:0] PERIOD,
  output logic       LOCKED,
  output logic       ERR,
  output logic [7:0] ERR_CNT
`ifdef NINJAKUN_CLKMON_DUTY_EN
  ,
  output logic [7:0] HIGH_TIME
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  // Acceptance window for a measured period, and the count at which a missing
  // rise is treated as a stall (one beyond the longest acceptable period).
  localparam logic [8:0] P_LO     = (EXP_PERIOD > TOL) ? 9'(EXP_PERIOD - TOL) : 9'd0;
  localparam logic [8:0] P_HI     = 9'(EXP_PERIOD + TOL);
  localparam logic [8:0] STALL_AT = 9'(EXP_PERIOD + TOL + 1);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic       p_q, p_d;
  logic       cen_rise_q, cen_rise_d;
  logic       cen_fall_q, cen_fall_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] period_q, period_d;
  logic [3:0] good_q, good_d;
  state_t     state_q, state_d;
  logic       err_q, err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       s_w;
  logic       rise, fall, stall;
  logic [7:0] cnt_inc;
  logic       period_ok, good_ok;
  logic       violation;

  assign s_w = sync_q[SYNC_STAGES-1];

`ifdef NINJAKUN_CLKMON_DUTY_EN
  localparam logic [8:0] H_LO = (EXP_PERIOD / 2 > TOL) ? 9'(EXP_PERIOD / 2 - TOL) : 9'd0;
  localparam logic [8:0] H_HI = 9'(EXP_PERIOD / 2 + TOL);

  logic [7:0] ht_q, ht_d;
  logic       duty_bad_q, duty_bad_d;

  // High-time capture on each fall; a bad duty is held until the next rise judges it.
  always_comb begin
    ht_d       = ht_q;
    duty_bad_d = duty_bad_q;
    if (fall) begin
      ht_d       = cnt_inc;
      duty_bad_d = (state_q != ST_IDLE) &&
                   !(({1'b0, cnt_inc} >= H_LO) && ({1'b0, cnt_inc} <= H_HI));
    end
    if (rise || stall) begin
      duty_bad_d = 1'b0;
    end
  end

  // Duty-check registers.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      ht_q       <= 8'd0;
      duty_bad_q <= 1'b0;
    end else begin
      ht_q       <= ht_d;
      duty_bad_q <= duty_bad_d;
    end
  end

  assign HIGH_TIME = ht_q;
  assign good_ok   = period_ok & ~duty_bad_q;
`else
  assign good_ok   = period_ok;
`endif

  // Synchronizer, edge detect and the free-running period counter.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], CLKIN};
    p_d        = s_w;
    rise       = s_w & ~p_q;
    fall       = ~s_w & p_q;
    cen_rise_d = rise;
    cen_fall_d = fall;
    cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    cnt_d      = rise ? 8'd0 : cnt_inc;
    period_ok  = ({1'b0, cnt_inc} >= P_LO) && ({1'b0, cnt_inc} <= P_HI);
    stall      = (state_q != ST_IDLE) && ({1'b0, cnt_q} == STALL_AT);
  end

  // Lock FSM next state, period capture and violation detection.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    period_d  = period_q;
    violation = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_ACQ;
          good_d  = 4'd0;
        end
      end
      ST_ACQ: begin
        if (stall) begin
          state_d = ST_IDLE;
          good_d  = 4'd0;
        end else if (rise) begin
          period_d = cnt_inc;
          if (good_ok) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_N) begin
              state_d = ST_LOCK;
            end
          end else begin
            good_d = 4'd0;
          end
        end
      end
      ST_LOCK: begin
        if (stall) begin
          state_d   = ST_IDLE;
          good_d    = 4'd0;
          violation = 1'b1;
        end else if (rise) begin
          period_d = cnt_inc;
          if (!good_ok) begin
            state_d   = ST_ACQ;
            good_d    = 4'd0;
            violation = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        good_d  = 4'd0;
      end
    endcase
  end

  // Sticky error flag and saturating count; a violation overrides a same-cycle clear.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (CLR_ERR) begin
      err_d     = 1'b0;
      err_cnt_d = 8'd0;
    end
    if (violation) begin
      err_d     = 1'b1;
      err_cnt_d = CLR_ERR ? 8'd1 :
                  (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end
  end

  // State registers.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      sync_q     <= '0;
      p_q        <= 1'b0;
      cen_rise_q <= 1'b0;
      cen_fall_q <= 1'b0;
      cnt_q      <= 8'd0;
      period_q   <= 8'd0;
      good_q     <= 4'd0;
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      sync_q     <= sync_d;
      p_q        <= p_d;
      cen_rise_q <= cen_rise_d;
      cen_fall_q <= cen_fall_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      good_q     <= good_d;
      state_q    <= state_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign CEN_RISE = cen_rise_q;
  assign CEN_FALL = cen_fall_q;
  assign PERIOD   = period_q;
  assign LOCKED   = (state_q == ST_LOCK);
  assign ERR      = err_q;
  assign ERR_CNT  = err_cnt_q;

endmodule
